// File: rtl/serial_5b_par_rx_if.sv
`timescale 1ns/1ps
// Line input and parallel display-side outputs of the 5-bit serial receiver.
interface serial_5b_par_rx_if;
    logic serial_in;
    logic b1;
    logic b2;
    logic b3;
    logic b4;
    logic b5;
    logic b_par;
    logic frame_valid;
    logic frame_err;
    logic par_err;
    logic busy;

    modport master (
        input  serial_in,
        output b1, b2, b3, b4, b5, b_par, frame_valid, frame_err, par_err, busy
    );

    modport slave (
        output serial_in,
        input  b1, b2, b3, b4, b5, b_par, frame_valid, frame_err, par_err, busy
    );
endinterface

// File: rtl/serial_5b_par_rx.sv
`timescale 1ns/1ps
// Deserialises start + 5 data + parity + stop frames for display_7_seg.
// The parallel outputs move only when a frame with a high stop bit completes.
module serial_5b_par_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               rst,
    serial_5b_par_rx_if.master bus
);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic            rx_s;
    logic [TW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [4:0]      shadow_q, shadow_d;
    logic            par_shadow_q, par_shadow_d;
    logic            load_d, ferr_d;
    logic [4:0]      data_q;
    logic            b_par_q, par_err_q, frame_valid_q, frame_err_q;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.serial_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            shadow_q     <= '0;
            par_shadow_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            shadow_q     <= shadow_d;
            par_shadow_q <= par_shadow_d;
        end
    end

    // tick_d returns to zero whenever the state changes
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shadow_d     = shadow_q;
        par_shadow_d = par_shadow_q;
        load_d       = 1'b0;
        ferr_d       = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (tick_q == TICK_MID) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d              = '0;
                    shadow_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd4) state_d = PARITY;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            PARITY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d       = '0;
                    par_shadow_d = rx_s;
                    state_d      = STOP;
                end
            end
            STOP: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    load_d  = rx_s;
                    ferr_d  = !rx_s;
                end
            end
            default: begin
                tick_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q        <= '0;
            b_par_q       <= 1'b0;
            par_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= load_d;
            frame_err_q   <= ferr_d;
            if (load_d) begin
                data_q    <= shadow_q;
                b_par_q   <= par_shadow_q;
                par_err_q <= (^{shadow_q, par_shadow_q}) != PAR_ODD;
            end
        end
    end

    // shadow/data bit 0 is the first data bit on the line (b1, MSB)
    assign bus.b1          = data_q[0];
    assign bus.b2          = data_q[1];
    assign bus.b3          = data_q[2];
    assign bus.b4          = data_q[3];
    assign bus.b5          = data_q[4];
    assign bus.b_par       = b_par_q;
    assign bus.par_err     = par_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_5b_par_rx.sv
`timescale 1ns/1ps
// Bench for serial_5b_par_rx: table vectors, corner-case sequences and random
// frames checked against a frame-level model of the display outputs.
module tb_serial_5b_par_rx;
    localparam int CPB     = 16;
    localparam int PAR_ODD = 0;
    localparam int LATENCY = 2 + CPB / 2 + 6 * CPB + CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_5b_par_rx_if bus_if ();

    serial_5b_par_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PAR_ODD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct {
        logic [4:0] data;
        logic       par;
        logic       stop;
        logic [4:0] exp_bits;
        logic       exp_bpar;
        logic       exp_perr;
        logic       exp_fv;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int fv_cnt = 0, fe_cnt = 0, viol = 0, last_fv_cyc = 0;
    logic [6:0] cap_q[$];
    logic [6:0] prev_out = '0;
    logic fv_prev = 1'b0, fe_prev = 1'b0;

    // expected display state held by the model
    logic [4:0] m_bits = '0;
    logic       m_bp = 1'b0, m_pe = 1'b0;

    function automatic logic [6:0] cur_out();
        return {bus_if.b1, bus_if.b2, bus_if.b3, bus_if.b4, bus_if.b5, bus_if.b_par, bus_if.par_err};
    endfunction

    function automatic logic model_perr(input logic [4:0] d, input logic p);
        return (($countones({d, p}) % 2) == 1) != (PAR_ODD != 0);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_out = cur_out();
            fv_prev  = 1'b0;
            fe_prev  = 1'b0;
        end else begin
            if (bus_if.frame_valid) begin
                fv_cnt++;
                last_fv_cyc = cyc;
                cap_q.push_back(cur_out());
            end
            if (bus_if.frame_err) fe_cnt++;
            if (bus_if.frame_valid && bus_if.frame_err) viol++;
            if (bus_if.frame_valid && fv_prev) viol++;
            if (bus_if.frame_err && fe_prev) viol++;
            if (cur_out() !== prev_out && !bus_if.frame_valid) viol++;
            prev_out = cur_out();
            fv_prev  = bus_if.frame_valid;
            fe_prev  = bus_if.frame_err;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        bus_if.serial_in = 1'b1;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        bus_if.serial_in = b;
        repeat (CPB) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [4:0] d, input logic p, input logic s);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 4; i >= 0; i--) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        bus_if.serial_in = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input logic exp_fv, input int fv0, input int fe0);
        logic [6:0] cap;
        @(negedge clk);
        chk({tag, " fv_count"}, fv_cnt - fv0, {31'd0, exp_fv});
        chk({tag, " fe_count"}, fe_cnt - fe0, {31'd0, !exp_fv});
        chk({tag, " outputs"}, {25'd0, cur_out()}, {25'd0, m_bits, m_bp, m_pe});
        if (exp_fv) begin
            chk({tag, " latency"}, last_fv_cyc - start_cyc, LATENCY);
            chk({tag, " captured"}, cap_q.size(), 1);
            if (cap_q.size() > 0) begin
                cap = cap_q.pop_front();
                chk({tag, " pulse_value"}, {25'd0, cap}, {25'd0, m_bits, m_bp, m_pe});
            end
        end
        cap_q.delete();
        @(posedge clk);
        #2;
    endtask

    task automatic model_frame(input string tag, input logic [4:0] d, input logic p, input logic s);
        int fv0, fe0;
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        if (s) begin
            m_bits = d;
            m_bp   = p;
            m_pe   = model_perr(d, p);
        end
        send_frame(d, p, s);
        expect_frame(tag, s, fv0, fe0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        m_bits = '0;
        m_bp   = 1'b0;
        m_pe   = 1'b0;
        cap_q.delete();
    endtask

    initial begin
        vec_t vecs[8];
        int fv0, fe0;
        logic [4:0] d, d2;
        logic p, s;
        logic [6:0] cap;

        vecs[0] = '{5'b10110, 1'b1, 1'b1, 5'b10110, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{5'b00001, 1'b0, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{5'b11111, 1'b1, 1'b1, 5'b11111, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{5'b00111, 1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5'b01010, 1'b0, 1'b1, 5'b01010, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{5'b11000, 1'b1, 1'b1, 5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{5'b00000, 1'b0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{5'b10000, 1'b0, 1'b1, 5'b10000, 1'b0, 1'b1, 1'b1};

        // reset and idle line
        bus_if.serial_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {25'd0, cur_out()}, 32'd0);
        chk("reset busy", {31'd0, bus_if.busy}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(500);
        @(negedge clk);
        chk("idle outputs", {25'd0, cur_out()}, 32'd0);
        chk("idle busy", {31'd0, bus_if.busy}, 32'd0);
        chk("idle fv_count", fv_cnt, 0);
        chk("idle fe_count", fe_cnt, 0);
        @(posedge clk);
        #2;

        // hand-written table vectors
        for (int i = 0; i < 8; i++) begin
            fv0 = fv_cnt;
            fe0 = fe_cnt;
            if (vecs[i].exp_fv) begin
                m_bits = vecs[i].exp_bits;
                m_bp   = vecs[i].exp_bpar;
                m_pe   = vecs[i].exp_perr;
            end
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_fv, fv0, fe0);
            idle(20);
        end

        // short low glitch must be rejected at the start mid-sample
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        bus_if.serial_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("glitch busy_rise", {31'd0, bus_if.busy}, 32'd1);
        @(posedge clk);
        #2;
        idle(20);
        @(negedge clk);
        chk("glitch busy_fall", {31'd0, bus_if.busy}, 32'd0);
        chk("glitch pulses", (fv_cnt - fv0) + (fe_cnt - fe0), 0);
        chk("glitch outputs", {25'd0, cur_out()}, {25'd0, m_bits, m_bp, m_pe});
        @(posedge clk);
        #2;

        // line stuck low: repeated framing errors, no lock-up, no data update
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        bus_if.serial_in = 1'b0;
        repeat (400) @(posedge clk);
        @(negedge clk);
        chk("stuck_low fe_count", fe_cnt - fe0, 3);
        chk("stuck_low fv_count", fv_cnt - fv0, 0);
        chk("stuck_low outputs", {25'd0, cur_out()}, {25'd0, m_bits, m_bp, m_pe});
        @(posedge clk);
        #2;
        do_reset();
        idle(20);

        // mid-frame reset
        model_frame("pre_reset", 5'b11011, 1'b0, 1'b1);
        idle(5);
        d = 5'b10110;
        drive_bit(1'b0);
        drive_bit(d[4]);
        drive_bit(d[3]);
        bus_if.serial_in = d[2];
        repeat (8) @(posedge clk);
        #2;
        chk("midframe busy", {31'd0, bus_if.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midframe reset outputs", {25'd0, cur_out()}, 32'd0);
        chk("midframe reset busy", {31'd0, bus_if.busy}, 32'd0);
        chk("midframe reset pulses", {30'd0, bus_if.frame_valid, bus_if.frame_err}, 32'd0);
        @(posedge clk);
        #2;
        do_reset();
        idle(20);
        model_frame("after_reset", 5'b01010, 1'b0, 1'b1);
        idle(5);

        // back-to-back frames without idle gap
        fv0 = fv_cnt;
        d  = 5'b10011;
        d2 = 5'b01101;
        cap_q.delete();
        send_frame(d, 1'b1, 1'b1);
        send_frame(d2, 1'b0, 1'b1);
        @(negedge clk);
        chk("b2b fv_count", fv_cnt - fv0, 2);
        chk("b2b captured", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            cap = cap_q.pop_front();
            chk("b2b first", {25'd0, cap}, {25'd0, d, 1'b1, model_perr(d, 1'b1)});
            cap = cap_q.pop_front();
            chk("b2b second", {25'd0, cap}, {25'd0, d2, 1'b0, model_perr(d2, 1'b0)});
        end
        cap_q.delete();
        m_bits = d2;
        m_bp   = 1'b0;
        m_pe   = model_perr(d2, 1'b0);
        @(posedge clk);
        #2;
        idle(5);

        // all 32 values with correct and inverted parity
        for (int v = 0; v < 32; v++) begin
            for (int inv = 0; inv < 2; inv++) begin
                d = 5'(v);
                p = (^d) ^ (PAR_ODD != 0) ^ inv[0];
                model_frame($sformatf("sweep d=%0d inv=%0d", v, inv), d, p, 1'b1);
                idle(2);
            end
        end

        // random frames, some with framing errors, random idle gaps
        for (int i = 0; i < 20; i++) begin
            d = 5'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            model_frame($sformatf("rand%0d d=%0d p=%0d s=%0d", i, d, p, s), d, p, s);
            if (s) idle($urandom_range(1, 8));
            else   idle($urandom_range(16, 24));
        end

        chk("pulse/output protocol violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_5b_par_rx.md
Name: serial_5b_par_rx

Overview:
- Serial receiver that directly feeds display_7_seg.
- Deserialises one asynchronous frame: start bit, 5 data bits, 1 parity bit, stop bit.
- Presents the data bits as b1..b5 and the received parity bit as b_par, matching display_7_seg's parallel inputs.
- Holds the last good frame stable so the display never sees a partially shifted value.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit period. Must be ≥4 and even.
- PARITY_ODD, 0: 0 = even parity expected; 1 = odd parity expected. Affects par_err only.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  asynchronous serial line; idle level 1.
- b1  output  1  data bit 1, MSB, first data bit on the line.
- b2  output  1  data bit 2.
- b3  output  1  data bit 3.
- b4  output  1  data bit 4.
- b5  output  1  data bit 5, LSB, last data bit on the line.
- b_par  output  1  parity bit exactly as received.
- frame_valid  output  1  1-cycle pulse when b1..b5/b_par have been updated.
- frame_err  output  1  1-cycle pulse when the stop bit was sampled low.
- par_err  output  1  registered with b1..b5; 1 when the frame's parity check fails.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, synchronous release): FSM=IDLE; b1..b5, b_par, frame_valid, frame_err, par_err, busy all 0; synchronizer flops preset to 1; bit counter and tick counter cleared.
- Input conditioning: serial_in passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s only. This adds 2 cycles of latency.
- Tick counter: counts 0..CLKS_PER_BIT-1 within a state and resets on every state change.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 → START.
  - START: at tick CLKS_PER_BIT/2-1 (mid-bit), sample rx_s.
    - 0 → DATA, with bit_idx=0 and tick counter cleared.
    - 1 → IDLE (glitch rejected; no pulse).
  - DATA: every CLKS_PER_BIT ticks, sample rx_s into shift register position bit_idx (0→b1 ... 4→b5).
    - After bit_idx==4 is sampled → PARITY.
  - PARITY: after CLKS_PER_BIT ticks, sample rx_s into par_shadow → STOP.
  - STOP: after CLKS_PER_BIT ticks, sample rx_s.
    - 1: in the next cycle, load b1..b5 and b_par from shadow, set par_err, and pulse frame_valid for 1 cycle.
    - 0: pulse frame_err for 1 cycle; outputs and par_err are NOT updated.
    - Both cases → IDLE.
    - A new start edge is accepted in the cycle after IDLE is re-entered.
- par_err = (b1^b2^b3^b4^b5^b_par) != PARITY_ODD. Even mode: total number of ones, including the parity bit, must be even.
- The block does NOT suppress frames on parity error. b_par is forwarded raw so that display_7_seg performs its own parity handling.
- Outputs b1..b5, b_par and par_err change only on frame_valid, i.e. exactly once per good frame, all in the same cycle.
- frame_valid and frame_err are mutually exclusive and never high for more than 1 cycle.
- busy = (state != IDLE).
- Latency: frame_valid rises 2 (sync) + CLKS_PER_BIT/2 + 6×CLKS_PER_BIT + CLKS_PER_BIT + 1 cycles after the falling edge of the start bit on serial_in. For CLKS_PER_BIT=16 this is 123 cycles.
- serial_in held low indefinitely: the frame is received with data 0, parity 0 and stop 0, giving a frame_err pulse. The FSM then re-enters IDLE, sees rx_s=0, and restarts; frame_err repeats once per frame time. There is no lock-up.
- Reset asserted mid-frame: the partial frame is discarded, all outputs return to 0 immediately, and no pulse is issued.

Test Plan:
- Reset then idle line: assert rst with serial_in=1, release, and run 500 cycles → all outputs 0, busy 0, no pulses.
- Good frame, CLKS_PER_BIT=16, even parity: send data 1,0,1,1,0 and parity 1 → {b1..b5}=10110, b_par=1, par_err=0, frame_valid pulse exactly 123 cycles after the start edge.
- Parity error: send data 0,0,0,0,1 with parity 0 → outputs update to 00001, b_par=0, par_err=1, frame_valid pulses.
- Framing error: send a good frame (11111, parity 1) followed by a frame 00111 parity 1 with stop=0 → frame_err pulses once; outputs still show 11111 with b_par=1.
- Glitch rejection: drive serial_in low for 4 cycles then high → busy rises then falls before the start mid-sample; no pulses; outputs unchanged.
- Mid-frame reset and back-to-back frames:
  - Assert rst during DATA bit 3 → outputs 0 immediately; the next full frame 01010 parity 0 is received correctly.
  - Two frames with no idle gap (stop bit followed immediately by a start bit) → two frame_valid pulses, both values correct.
  - Sweep all 32 data values, each with correct and with inverted parity → par_err matches expectation for all 64 frames.
